// File: rtl/scalar_wb_arbiter.sv
// Round-robin write-back arbiter driving the scalar register file write port, plus a
// pending-write busy scoreboard. Define SCALAR_WB_FWD_EN to let an in-flight write clear its hazard.
module scalar_wb_arbiter #(
  parameter int BIT_NUMBER      = 32,
  parameter int ADDR_NUMBER     = 5,
  parameter int REGISTER_NUMBER = 16,
  parameter int REQ_NUMBER      = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [REQ_NUMBER-1:0]             req_valid,
  input  logic [REQ_NUMBER*ADDR_NUMBER-1:0] req_addr,
  input  logic [REQ_NUMBER*BIT_NUMBER-1:0]  req_data,
  output logic [REQ_NUMBER-1:0]             req_ready,
  output logic                              write_enable,
  output logic [ADDR_NUMBER-1:0]            dest_addr,
  output logic [BIT_NUMBER-1:0]             write_data,
  input  logic                              claim_valid,
  input  logic [ADDR_NUMBER-1:0]            claim_addr,
  input  logic [ADDR_NUMBER-1:0]            chk_addr_1,
  input  logic [ADDR_NUMBER-1:0]            chk_addr_2,
  output logic                              hazard_1,
  output logic                              hazard_2,
  output logic [REGISTER_NUMBER-1:0]        busy_vector
);

  localparam int PTR_W = $clog2(REQ_NUMBER);
  localparam logic [ADDR_NUMBER:0] REG_LIMIT = (ADDR_NUMBER+1)'(REGISTER_NUMBER);

  logic [PTR_W-1:0]           ptr;
  logic [PTR_W-1:0]           grant_idx;
  logic [PTR_W-1:0]           ptr_next;
  logic                       grant_found;
  logic [ADDR_NUMBER-1:0]     win_addr;
  logic [BIT_NUMBER-1:0]      win_data;
  logic [REGISTER_NUMBER-1:0] busy_next;
  logic [REGISTER_NUMBER-1:0] sel_1;
  logic [REGISTER_NUMBER-1:0] sel_2;
  logic                       base_1;
  logic                       base_2;

  // Scan requesters starting at ptr, wrapping, and take the first valid one.
  always_comb begin
    int j;
    grant_found = 1'b0;
    grant_idx   = ptr;
    j           = 0;
    for (int k = 0; k < REQ_NUMBER; k++) begin
      j = int'(ptr) + k;
      if (j >= REQ_NUMBER) j = j - REQ_NUMBER;
      if (!grant_found && req_valid[j[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = j[PTR_W-1:0];
      end
    end
    ptr_next  = (grant_idx == PTR_W'(REQ_NUMBER - 1)) ? '0 : grant_idx + 1'b1;
    req_ready = (grant_found && reset) ? (REQ_NUMBER'(1) << grant_idx) : '0;
  end

  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < REQ_NUMBER; i++) begin
      if (PTR_W'(i) == grant_idx) begin
        win_addr = req_addr[i*ADDR_NUMBER +: ADDR_NUMBER];
        win_data = req_data[i*BIT_NUMBER +: BIT_NUMBER];
      end
    end
  end

  // Claim is applied after the clear so a same-address collision leaves the bit set.
  always_comb begin
    busy_next = busy_vector;
    if (write_enable && ({1'b0, dest_addr} < REG_LIMIT))
      busy_next = busy_next & ~(REGISTER_NUMBER'(1) << dest_addr);
    if (claim_valid && ({1'b0, claim_addr} < REG_LIMIT))
      busy_next = busy_next | (REGISTER_NUMBER'(1) << claim_addr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr          <= '0;
      write_enable <= 1'b0;
      dest_addr    <= '0;
      write_data   <= '0;
      busy_vector  <= '0;
    end else begin
      busy_vector  <= busy_next;
      write_enable <= grant_found;
      if (grant_found) begin
        ptr        <= ptr_next;
        dest_addr  <= win_addr;
        write_data <= win_data;
      end
    end
  end

  always_comb begin
    sel_1  = busy_vector >> chk_addr_1;
    sel_2  = busy_vector >> chk_addr_2;
    base_1 = ({1'b0, chk_addr_1} < REG_LIMIT) && sel_1[0];
    base_2 = ({1'b0, chk_addr_2} < REG_LIMIT) && sel_2[0];
`ifdef SCALAR_WB_FWD_EN
    hazard_1 = base_1 && !(write_enable && (dest_addr == chk_addr_1));
    hazard_2 = base_2 && !(write_enable && (dest_addr == chk_addr_2));
`else
    hazard_1 = base_1;
    hazard_2 = base_2;
`endif
  end

endmodule

// File: tb/tb_scalar_wb_arbiter.sv
// Bench for scalar_wb_arbiter: round-robin table, hand-built scoreboard corner cases,
// and randomized traffic against a reference model of the arbitration and busy rules.
module tb_scalar_wb_arbiter;

  localparam int BW = 32;
  localparam int AW = 5;
  localparam int RN = 16;
  localparam int RQ = 3;

  logic              clk;
  logic              reset;
  logic [RQ-1:0]     req_valid;
  logic [RQ*AW-1:0]  req_addr;
  logic [RQ*BW-1:0]  req_data;
  logic [RQ-1:0]     req_ready;
  logic              write_enable;
  logic [AW-1:0]     dest_addr;
  logic [BW-1:0]     write_data;
  logic              claim_valid;
  logic [AW-1:0]     claim_addr;
  logic [AW-1:0]     chk_addr_1;
  logic [AW-1:0]     chk_addr_2;
  logic              hazard_1;
  logic              hazard_2;
  logic [RN-1:0]     busy_vector;

  int n_cmp;
  int n_fail;

  int          m_ptr;
  logic        m_we;
  logic [AW-1:0] m_dest;
  logic [BW-1:0] m_data;
  logic        m_busy [RN];

  typedef struct packed {
    logic [RQ-1:0] valid;
    logic [RQ-1:0] ready;
    logic          we;
    logic [AW-1:0] dest;
  } rr_vec_t;

  rr_vec_t rr_tab [12];
  logic    hz_exp [6];

  scalar_wb_arbiter #(
    .BIT_NUMBER(BW), .ADDR_NUMBER(AW), .REGISTER_NUMBER(RN), .REQ_NUMBER(RQ)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .write_enable(write_enable), .dest_addr(dest_addr), .write_data(write_data),
    .claim_valid(claim_valid), .claim_addr(claim_addr),
    .chk_addr_1(chk_addr_1), .chk_addr_2(chk_addr_2),
    .hazard_1(hazard_1), .hazard_2(hazard_2), .busy_vector(busy_vector)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int model_grant();
    for (int k = 0; k < RQ; k++) begin
      int j;
      j = (m_ptr + k) % RQ;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [RQ-1:0] model_ready();
    int g;
    logic [RQ-1:0] r;
    g = model_grant();
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic logic [RN-1:0] model_busy();
    logic [RN-1:0] v;
    for (int r = 0; r < RN; r++) v[r] = m_busy[r];
    return v;
  endfunction

  function automatic logic model_hazard(input logic [AW-1:0] a);
    logic h;
    if (int'(a) >= RN) return 1'b0;
    h = m_busy[a];
`ifdef SCALAR_WB_FWD_EN
    if (m_we && m_dest == a) h = 1'b0;
`endif
    return h;
  endfunction

  task automatic model_reset();
    m_ptr  = 0;
    m_we   = 1'b0;
    m_dest = '0;
    m_data = '0;
    for (int r = 0; r < RN; r++) m_busy[r] = 1'b0;
  endtask

  task automatic model_step();
    int   g;
    logic nb [RN];
    g = model_grant();
    for (int r = 0; r < RN; r++) begin
      nb[r] = m_busy[r];
      if (m_we && int'(m_dest) == r) nb[r] = 1'b0;
      if (claim_valid && int'(claim_addr) == r) nb[r] = 1'b1;
    end
    for (int r = 0; r < RN; r++) m_busy[r] = nb[r];
    if (g >= 0) begin
      m_we   = 1'b1;
      m_dest = req_addr[g*AW +: AW];
      m_data = req_data[g*BW +: BW];
      m_ptr  = (g + 1) % RQ;
    end else begin
      m_we = 1'b0;
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    checkOutput("req_ready",    64'(req_ready),    64'(model_ready()));
    checkOutput("write_enable", 64'(write_enable), 64'(m_we));
    checkOutput("dest_addr",    64'(dest_addr),    64'(m_dest));
    checkOutput("write_data",   64'(write_data),   64'(m_data));
    checkOutput("busy_vector",  64'(busy_vector),  64'(model_busy()));
    checkOutput("hazard_1",     64'(hazard_1),     64'(model_hazard(chk_addr_1)));
    checkOutput("hazard_2",     64'(hazard_2),     64'(model_hazard(chk_addr_2)));
  endtask

  // Advance one cycle: model and DUT both take the edge, then inputs may change.
  task automatic applyStimulus();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [BW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*BW +: BW] = d;
  endtask

  task automatic idle_inputs();
    req_valid   = '0;
    claim_valid = 1'b0;
    claim_addr  = '0;
    chk_addr_1  = '0;
    chk_addr_2  = '0;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    model_reset();
    reset = 1'b0;
    idle_inputs();
    req_valid = 3'b111;
    for (int i = 0; i < RQ; i++) set_req(i, AW'(i + 1), BW'(32'hA0 + i));

    // Reset held with all requesters active.
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_write_enable", 64'(write_enable), 64'd0);
      checkOutput("rst_busy_vector",  64'(busy_vector),  64'd0);
      checkOutput("rst_dest_addr",    64'(dest_addr),    64'd0);
      checkOutput("rst_write_data",   64'(write_data),   64'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();

    // Round-robin table.
    rr_tab[0]  = '{3'b111, 3'b001, 1'b0, 5'd0};
    rr_tab[1]  = '{3'b111, 3'b010, 1'b1, 5'd1};
    rr_tab[2]  = '{3'b111, 3'b100, 1'b1, 5'd2};
    rr_tab[3]  = '{3'b111, 3'b001, 1'b1, 5'd3};
    rr_tab[4]  = '{3'b111, 3'b010, 1'b1, 5'd1};
    rr_tab[5]  = '{3'b111, 3'b100, 1'b1, 5'd2};
    rr_tab[6]  = '{3'b000, 3'b000, 1'b1, 5'd3};
    rr_tab[7]  = '{3'b000, 3'b000, 1'b0, 5'd3};
    rr_tab[8]  = '{3'b010, 3'b010, 1'b0, 5'd3};
    rr_tab[9]  = '{3'b101, 3'b100, 1'b1, 5'd2};
    rr_tab[10] = '{3'b101, 3'b001, 1'b1, 5'd3};
    rr_tab[11] = '{3'b000, 3'b000, 1'b1, 5'd1};
    for (int t = 0; t < 12; t++) begin
      req_valid = rr_tab[t].valid;
      @(negedge clk);
      checkOutput($sformatf("rr_ready[%0d]", t), 64'(req_ready),    64'(rr_tab[t].ready));
      checkOutput($sformatf("rr_we[%0d]", t),    64'(write_enable), 64'(rr_tab[t].we));
      checkOutput($sformatf("rr_dest[%0d]", t),  64'(dest_addr),    64'(rr_tab[t].dest));
      check_all();
      applyStimulus();
    end

    // Claim-to-clear latency on register 5.
    hz_exp = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`ifdef SCALAR_WB_FWD_EN
    hz_exp[4] = 1'b0;
`endif
    idle_inputs();
    chk_addr_1 = 5'd5;
    set_req(1, 5'd5, 32'h5555_0001);
    for (int c = 0; c < 6; c++) begin
      claim_valid = (c == 0);
      claim_addr  = 5'd5;
      req_valid   = (c == 3) ? 3'b010 : 3'b000;
      @(negedge clk);
      checkOutput($sformatf("lat_hazard_1[%0d]", c), 64'(hazard_1), 64'(hz_exp[c]));
      if (c == 4) checkOutput("lat_we", 64'(write_enable), 64'd1);
      check_all();
      applyStimulus();
    end

    // Claim and clear colliding on register 7.
    idle_inputs();
    set_req(0, 5'd7, 32'h7777_0000);
    for (int c = 0; c < 6; c++) begin
      claim_valid = (c == 0 || c == 2);
      claim_addr  = 5'd7;
      req_valid   = (c == 1 || c == 3) ? 3'b001 : 3'b000;
      @(negedge clk);
      if (c == 2) checkOutput("col_we_dest", 64'({write_enable, dest_addr}), 64'({1'b1, 5'd7}));
      if (c == 3) checkOutput("col_busy_held", 64'(busy_vector), 64'h0080);
      if (c == 5) checkOutput("col_busy_clear", 64'(busy_vector), 64'h0000);
      check_all();
      applyStimulus();
    end

    // Out-of-range address 20: written out, never tracked.
    idle_inputs();
    chk_addr_2 = 5'd20;
    set_req(2, 5'd20, 32'h2020_2020);
    for (int c = 0; c < 3; c++) begin
      claim_valid = (c == 0);
      claim_addr  = 5'd20;
      req_valid   = (c == 0) ? 3'b100 : 3'b000;
      @(negedge clk);
      if (c == 1) begin
        checkOutput("oor_we_dest", 64'({write_enable, dest_addr}), 64'({1'b1, 5'd20}));
        checkOutput("oor_data", 64'(write_data), 64'h2020_2020);
      end
      if (c >= 1) begin
        checkOutput($sformatf("oor_busy[%0d]", c), 64'(busy_vector), 64'h0);
        checkOutput($sformatf("oor_hazard_2[%0d]", c), 64'(hazard_2), 64'h0);
      end
      check_all();
      applyStimulus();
    end

    // Randomized traffic; losing requesters keep their request stable.
    idle_inputs();
    for (int i = 0; i < RQ; i++) begin
      req_valid[i] = ($urandom_range(0, 1) == 1);
      set_req(i, AW'($urandom_range(0, 31)), BW'($urandom));
    end
    for (int c = 0; c < 400; c++) begin
      int g;
      claim_valid = ($urandom_range(0, 3) == 0);
      claim_addr  = AW'($urandom_range(0, 19));
      chk_addr_1  = AW'($urandom_range(0, 17));
      chk_addr_2  = AW'($urandom_range(0, 17));
      @(negedge clk);
      check_all();
      g = model_grant();
      applyStimulus();
      for (int i = 0; i < RQ; i++) begin
        if (!req_valid[i] || i == g) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          set_req(i, AW'($urandom_range(0, 31)), BW'($urandom));
        end
      end
    end

    // Reset pulse, then build busy=00F0 with a write in flight and reset asynchronously.
    idle_inputs();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
    set_req(0, 5'd9, 32'h0909_0909);
    for (int c = 0; c < 4; c++) begin
      claim_valid = 1'b1;
      claim_addr  = AW'(4 + c);
      req_valid   = (c == 3) ? 3'b001 : 3'b000;
      @(negedge clk);
      check_all();
      applyStimulus();
    end
    idle_inputs();
    chk_addr_1 = 5'd4;
    @(negedge clk);
    checkOutput("pre_rst_busy", 64'(busy_vector), 64'h00F0);
    checkOutput("pre_rst_we",   64'(write_enable), 64'd1);
    check_all();
    #1;
    reset = 1'b0;
    #1;
    checkOutput("async_rst_we",       64'(write_enable), 64'd0);
    checkOutput("async_rst_dest",     64'(dest_addr),    64'd0);
    checkOutput("async_rst_data",     64'(write_data),   64'd0);
    checkOutput("async_rst_busy",     64'(busy_vector),  64'd0);
    checkOutput("async_rst_hazard_1", 64'(hazard_1),     64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    check_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
